// File: rtl/burrito_pkg.sv
// Shared constants and controller state encoding for the Burrito instruction RAM path.
package burrito_pkg;

  localparam int unsigned DW_DEFAULT = 20;
  localparam int unsigned AW_DEFAULT = 3;
  localparam int unsigned RAM_DEPTH  = 5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LD_WAIT  = 3'd1,
    S_LD_WRITE = 3'd2,
    S_FT_ADDR  = 3'd3,
    S_FT_OUT   = 3'd4
  } state_e;

endpackage

// File: rtl/ram_fetch_ctrl.sv
// Master-side controller for the asynchronous instruction RAM: loads an upstream
// word stream into RAM[0..DEPTH-1] and streams RAM contents out over valid/ready.
module ram_fetch_ctrl
  import burrito_pkg::*;
#(
  parameter int unsigned DEPTH = RAM_DEPTH,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT,
  parameter bit          LOOP  = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_load,
  input  logic          start_fetch,
  input  logic          abort,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          instr_valid,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_addr,
  input  logic          instr_ready,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write_on,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          load_ready_q, load_ready_d;
  logic          instr_valid_q, instr_valid_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [AW-1:0] instr_addr_q, instr_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] mem_address_q, mem_address_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_write_on_q, mem_write_on_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      load_ready_q   <= 1'b0;
      instr_valid_q  <= 1'b0;
      instr_q        <= '0;
      instr_addr_q   <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      mem_address_q  <= '0;
      mem_wdata_q    <= '0;
      mem_write_on_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      load_ready_q   <= load_ready_d;
      instr_valid_q  <= instr_valid_d;
      instr_q        <= instr_d;
      instr_addr_q   <= instr_addr_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      mem_address_q  <= mem_address_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_write_on_q <= mem_write_on_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    load_ready_d   = 1'b0;
    instr_valid_d  = instr_valid_q;
    instr_d        = instr_q;
    instr_addr_d   = instr_addr_q;
    done_d         = 1'b0;
    mem_address_d  = mem_address_q;
    mem_wdata_d    = mem_wdata_q;
    mem_write_on_d = 1'b0;

    if (abort) begin
      state_d       = S_IDLE;
      ptr_d         = '0;
      instr_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_load) begin
            state_d      = S_LD_WAIT;
            ptr_d        = '0;
            load_ready_d = 1'b1;
          end else if (start_fetch) begin
            state_d = S_FT_ADDR;
            ptr_d   = '0;
          end
        end
        S_LD_WAIT: begin
          if (load_valid && load_ready_q) begin
            mem_address_d  = ptr_q;
            mem_wdata_d    = load_data;
            mem_write_on_d = 1'b1;
            state_d        = S_LD_WRITE;
          end else begin
            load_ready_d = 1'b1;
          end
        end
        // writeOn falls here while address/data hold, so the level-sensitive RAM sees a clean pulse
        S_LD_WRITE: begin
          if (ptr_q == LAST) begin
            done_d  = 1'b1;
            ptr_d   = '0;
            state_d = S_IDLE;
          end else begin
            ptr_d        = ptr_q + AW'(1);
            load_ready_d = 1'b1;
            state_d      = S_LD_WAIT;
          end
        end
        S_FT_ADDR: begin
          mem_address_d = ptr_q;
          state_d       = S_FT_OUT;
        end
        S_FT_OUT: begin
          if (!instr_valid_q) begin
            instr_d       = mem_rdata;
            instr_addr_d  = ptr_q;
            instr_valid_d = 1'b1;
          end else if (instr_ready) begin
            instr_valid_d = 1'b0;
            if (ptr_q != LAST) begin
              ptr_d   = ptr_q + AW'(1);
              state_d = S_FT_ADDR;
            end else if (LOOP) begin
              ptr_d   = '0;
              state_d = S_FT_ADDR;
            end else begin
              done_d  = 1'b1;
              ptr_d   = '0;
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign load_ready   = load_ready_q;
  assign instr_valid  = instr_valid_q;
  assign instr        = instr_q;
  assign instr_addr   = instr_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_address  = mem_address_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_write_on = mem_write_on_q;

endmodule

// File: tb/tb_ram_fetch_ctrl.sv
// Directed bench for ram_fetch_ctrl: one non-looping controller on a RAM model,
// one looping controller on a fixed-content memory.
`timescale 1ns/1ps
module tb_ram_fetch_ctrl;
  import burrito_pkg::*;

  localparam int unsigned DW = DW_DEFAULT;
  localparam int unsigned AW = AW_DEFAULT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start_load, start_fetch, abort, load_valid, instr_ready;
  logic [DW-1:0] load_data;
  logic          load_ready, instr_valid, busy, done, mem_write_on;
  logic [DW-1:0] instr, mem_wdata, mem_rdata;
  logic [AW-1:0] instr_addr, mem_address;

  logic          lp_start_fetch, lp_abort, lp_instr_ready;
  logic          lp_start_load, lp_load_valid;
  logic [DW-1:0] lp_load_data;
  logic          lp_load_ready, lp_instr_valid, lp_busy, lp_done, lp_mem_write_on;
  logic [DW-1:0] lp_instr, lp_mem_wdata, lp_mem_rdata;
  logic [AW-1:0] lp_instr_addr, lp_mem_address;

  int tests_run = 0;
  int tests_failed = 0;

  ram_fetch_ctrl #(.DEPTH(5), .AW(AW), .DW(DW), .LOOP(1'b0)) dut (
    .clk(clk), .reset(reset), .start_load(start_load), .start_fetch(start_fetch),
    .abort(abort), .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_addr(instr_addr),
    .instr_ready(instr_ready), .busy(busy), .done(done), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_write_on(mem_write_on), .mem_rdata(mem_rdata)
  );

  ram_fetch_ctrl #(.DEPTH(5), .AW(AW), .DW(DW), .LOOP(1'b1)) dut_lp (
    .clk(clk), .reset(reset), .start_load(lp_start_load), .start_fetch(lp_start_fetch),
    .abort(lp_abort), .load_valid(lp_load_valid), .load_data(lp_load_data),
    .load_ready(lp_load_ready), .instr_valid(lp_instr_valid), .instr(lp_instr),
    .instr_addr(lp_instr_addr), .instr_ready(lp_instr_ready), .busy(lp_busy),
    .done(lp_done), .mem_address(lp_mem_address), .mem_wdata(lp_mem_wdata),
    .mem_write_on(lp_mem_write_on), .mem_rdata(lp_mem_rdata)
  );

  // Behavioural stand-in for ram_async: combinational read, write while writeOn is high
  logic [DW-1:0] ram [0:(1<<AW)-1];
  assign mem_rdata = ram[mem_address];
  always @(posedge clk) if (mem_write_on) ram[mem_address] <= mem_wdata;

  assign lp_mem_rdata = 20'h00010 + DW'(lp_mem_address);

  int   wr_cnt = 0, wr_long = 0, done_cnt = 0, lp_done_cnt = 0;
  logic we_prev = 1'b0;
  logic [AW-1:0] wr_addr_q[$];
  always @(posedge clk) begin
    if (mem_write_on) begin
      wr_cnt <= wr_cnt + 1;
      wr_addr_q.push_back(mem_address);
      if (we_prev) wr_long <= wr_long + 1;
    end
    we_prev <= mem_write_on;
    if (done) done_cnt <= done_cnt + 1;
    if (lp_done) lp_done_cnt <= lp_done_cnt + 1;
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    tests_run++; if (load_ready !== 1'b0 || instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_handshake: got %b%b want 00", load_ready, instr_valid); end
    tests_run++; if (instr !== 20'h0 || instr_addr !== 3'd0) begin tests_failed++; $display("FAIL reset_instr: got %h/%0d want 0/0", instr, instr_addr); end
    tests_run++; if (mem_write_on !== 1'b0 || mem_address !== 3'd0 || mem_wdata !== 20'h0) begin tests_failed++; $display("FAIL reset_mem: got we=%b a=%0d d=%h want 0", mem_write_on, mem_address, mem_wdata); end
    tests_run++; if (lp_busy !== 1'b0 || lp_instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_lp: got %b%b want 00", lp_busy, lp_instr_valid); end
    reset = 1'b0;
  endtask

  task automatic test_load();
    int n;
    int wbase, dbase;
    wbase = wr_cnt; dbase = done_cnt;
    start_load = 1'b1; @(posedge clk); #1; start_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_data = 20'(i + 1); load_valid = 1'b1;
      n = 0;
      while (!load_ready && n < 10) begin @(posedge clk); #1; n++; end
      tests_run++; if (n !== 0) begin tests_failed++; $display("FAIL load_rate word %0d: got %0d stall cycles want 0", i, n); end
      @(posedge clk); #1;
      tests_run++; if (mem_write_on !== 1'b1 || mem_address !== 3'(i) || mem_wdata !== 20'(i + 1)) begin tests_failed++; $display("FAIL load_write word %0d: got we=%b a=%0d d=%h want 1/%0d/%h", i, mem_write_on, mem_address, mem_wdata, i, i + 1); end
      @(posedge clk); #1;
      tests_run++; if (mem_write_on !== 1'b0 || done !== (i == 4)) begin tests_failed++; $display("FAIL load_post word %0d: got we=%b done=%b want 0/%b", i, mem_write_on, done, i == 4); end
    end
    load_valid = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL load_busy_end: got %b want 0", busy); end
    @(posedge clk); #1;
    tests_run++; if (done !== 1'b0 || done_cnt - dbase !== 1) begin tests_failed++; $display("FAIL load_done_pulse: got done=%b pulses=%0d want 0/1", done, done_cnt - dbase); end
    tests_run++; if (wr_cnt - wbase !== 5 || wr_long !== 0) begin tests_failed++; $display("FAIL load_pulses: got %0d pulses, %0d long want 5, 0", wr_cnt - wbase, wr_long); end
    for (int k = 0; k < 5; k++) begin
      tests_run++; if (ram[k] !== 20'(k + 1) || wr_addr_q[wbase + k] !== 3'(k)) begin tests_failed++; $display("FAIL load_ram[%0d]: got %h at a=%0d want %h", k, ram[k], wr_addr_q[wbase + k], k + 1); end
    end
  endtask

  task automatic test_fetch();
    int n;
    instr_ready = 1'b1;
    start_fetch = 1'b1; @(posedge clk); #1; start_fetch = 1'b0;
    tests_run++; if (busy !== 1'b1 || instr_valid !== 1'b0) begin tests_failed++; $display("FAIL fetch_start: got busy=%b v=%b want 1/0", busy, instr_valid); end
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!instr_valid && n < 10) begin @(posedge clk); #1; n++; end
      tests_run++; if (n !== 2) begin tests_failed++; $display("FAIL fetch_latency word %0d: got %0d want 2", i, n); end
      tests_run++; if (instr !== 20'(i + 1) || instr_addr !== 3'(i)) begin tests_failed++; $display("FAIL fetch_word %0d: got %h@%0d want %h@%0d", i, instr, instr_addr, i + 1, i); end
      @(posedge clk); #1;
      tests_run++; if (instr_valid !== 1'b0 || done !== (i == 4) || busy !== (i != 4)) begin tests_failed++; $display("FAIL fetch_accept %0d: got v=%b done=%b busy=%b", i, instr_valid, done, busy); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    instr_ready = 1'b1;
    start_fetch = 1'b1; @(posedge clk); #1; start_fetch = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!instr_valid && n < 10) begin @(posedge clk); #1; n++; end
      tests_run++; if (instr !== 20'(i + 1) || instr_addr !== 3'(i)) begin tests_failed++; $display("FAIL bp_word %0d: got %h@%0d want %h@%0d", i, instr, instr_addr, i + 1, i); end
      if (i == 2) begin
        instr_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
          @(posedge clk); #1;
          tests_run++; if (instr_valid !== 1'b1 || instr !== 20'h00003 || instr_addr !== 3'd2) begin tests_failed++; $display("FAIL bp_hold cycle %0d: got v=%b %h@%0d want 1 00003@2", c, instr_valid, instr, instr_addr); end
        end
        instr_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    tests_run++; if (busy !== 1'b0 || done !== 1'b1) begin tests_failed++; $display("FAIL bp_end: got busy=%b done=%b want 0/1", busy, done); end
  endtask

  task automatic test_loop();
    int n;
    int dbase;
    dbase = lp_done_cnt;
    lp_instr_ready = 1'b1;
    lp_start_fetch = 1'b1; @(posedge clk); #1; lp_start_fetch = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n = 0;
      while (!lp_instr_valid && n < 10) begin @(posedge clk); #1; n++; end
      tests_run++; if (lp_instr_addr !== 3'(i % 5) || lp_instr !== 20'(16 + (i % 5))) begin tests_failed++; $display("FAIL loop_word %0d: got %h@%0d want %h@%0d", i, lp_instr, lp_instr_addr, 16 + (i % 5), i % 5); end
      @(posedge clk); #1;
    end
    tests_run++; if (lp_busy !== 1'b1 || lp_done_cnt - dbase !== 0) begin tests_failed++; $display("FAIL loop_no_done: got busy=%b pulses=%0d want 1/0", lp_busy, lp_done_cnt - dbase); end
    lp_abort = 1'b1; @(posedge clk); #1; lp_abort = 1'b0;
    tests_run++; if (lp_busy !== 1'b0 || lp_instr_valid !== 1'b0 || lp_done !== 1'b0) begin tests_failed++; $display("FAIL loop_abort: got busy=%b v=%b done=%b want 000", lp_busy, lp_instr_valid, lp_done); end
  endtask

  task automatic test_collision();
    int dbase;
    dbase = done_cnt;
    start_load = 1'b1; start_fetch = 1'b1; @(posedge clk); #1;
    start_load = 1'b0; start_fetch = 1'b0;
    tests_run++; if (load_ready !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL collide_load_wins: got rdy=%b busy=%b want 1/1", load_ready, busy); end
    start_fetch = 1'b1; @(posedge clk); #1; start_fetch = 1'b0;
    tests_run++; if (load_ready !== 1'b1 || instr_valid !== 1'b0 || mem_write_on !== 1'b0) begin tests_failed++; $display("FAIL start_ignored: got rdy=%b v=%b we=%b want 1/0/0", load_ready, instr_valid, mem_write_on); end
    load_data = 20'hABCDE; load_valid = 1'b1; @(posedge clk); #1; load_valid = 1'b0;
    tests_run++; if (mem_write_on !== 1'b1 || mem_address !== 3'd0) begin tests_failed++; $display("FAIL collide_write: got we=%b a=%0d want 1/0", mem_write_on, mem_address); end
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    tests_run++; if (busy !== 1'b0 || mem_write_on !== 1'b0 || load_ready !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL abort_ldwrite: got busy=%b we=%b rdy=%b done=%b want 0000", busy, mem_write_on, load_ready, done); end
    tests_run++; if (ram[0] !== 20'hABCDE || ram[1] !== 20'h00002 || done_cnt - dbase !== 0) begin tests_failed++; $display("FAIL abort_ram: got %h %h pulses=%0d want abcde 00002 0", ram[0], ram[1], done_cnt - dbase); end
  endtask

  task automatic test_abort_fetch();
    int n;
    instr_ready = 1'b0;
    start_fetch = 1'b1; @(posedge clk); #1; start_fetch = 1'b0;
    n = 0;
    while (!instr_valid && n < 10) begin @(posedge clk); #1; n++; end
    tests_run++; if (instr !== 20'hABCDE || instr_addr !== 3'd0) begin tests_failed++; $display("FAIL refetch_addr0: got %h@%0d want abcde@0", instr, instr_addr); end
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    tests_run++; if (instr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL abort_fetch: got v=%b busy=%b done=%b want 000", instr_valid, busy, done); end
    start_load = 1'b1; @(posedge clk); #1; start_load = 1'b0;
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    tests_run++; if (load_ready !== 1'b0 || busy !== 1'b0 || instr !== 20'h0) begin tests_failed++; $display("FAIL reset_midop: got rdy=%b busy=%b instr=%h want 0/0/0", load_ready, busy, instr); end
    instr_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start_load = 1'b0; start_fetch = 1'b0; abort = 1'b0;
    load_valid = 1'b0; load_data = '0; instr_ready = 1'b0;
    lp_start_fetch = 1'b0; lp_abort = 1'b0; lp_instr_ready = 1'b0;
    lp_start_load = 1'b0; lp_load_valid = 1'b0; lp_load_data = '0;
    test_reset();
    @(posedge clk); #1;
    test_load();
    test_fetch();
    test_backpressure();
    test_loop();
    test_collision();
    test_abort_fetch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
